mul_arb: RTL and testbench

MUL_ARB -- requirements
Module: mul_arb

---
 rtl/mul_arb.sv | 156 +++++++++++++++
 tb/tb_mul_arb.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arb.sv
// Two-requester round-robin front end for a shared multi-cycle multiplier.
// Optional BUSY watchdog enabled by defining MUL_ARB_TIMEOUT_EN.
module mul_arb #(
   parameter int unsigned SIZE    = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            r0_valid,
   input  logic [SIZE-1:0] r0_op1,
   input  logic [SIZE-1:0] r0_op2,
   input  logic [2:0]      r0_op,
   output logic            r0_ready,
   output logic            r0_rsp_valid,
   output logic [SIZE-1:0] r0_result,
   output logic            r0_rsp_err,
   input  logic            r1_valid,
   input  logic [SIZE-1:0] r1_op1,
   input  logic [SIZE-1:0] r1_op2,
   input  logic [2:0]      r1_op,
   output logic            r1_ready,
   output logic            r1_rsp_valid,
   output logic [SIZE-1:0] r1_result,
   output logic            r1_rsp_err,
   output logic            mul_start,
   output logic [SIZE-1:0] mul_op1,
   output logic [SIZE-1:0] mul_op2,
   output logic [2:0]      mul_op,
   input  logic [SIZE-1:0] mul_result,
   input  logic            mul_done,
   output logic            busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("mul_arb: TIMEOUT must be at least 1");
   end

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic            last_gnt;   // also identifies the owner of the in-flight op
   logic            accept;
   logic            sel;
   logic            rsp;
   logic [SIZE-1:0] res_val;

`ifdef MUL_ARB_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   logic [TW-1:0] tcnt;
   logic          tmo;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next state, arbitration and completion decode
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      rsp       = 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
      tmo       = 1'b0;
`endif
      sel = (r0_valid && r1_valid) ? ~last_gnt : r1_valid;
      case (state)
         IDLE: begin
            if (!rst && (r0_valid || r1_valid)) begin
               accept    = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (mul_done) begin
               rsp       = 1'b1;
               state_nxt = GAP;
            end
`ifdef MUL_ARB_TIMEOUT_EN
            else if (tcnt == TW'(TIMEOUT - 1)) begin
               rsp       = 1'b1;
               tmo       = 1'b1;
               state_nxt = GAP;
            end
`endif
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign r0_ready = accept & ~sel;
   assign r1_ready = accept & sel;

`ifdef MUL_ARB_TIMEOUT_EN
   assign res_val = tmo ? '0 : mul_result;
`else
   assign res_val = mul_result;
`endif

   // captured operands, grant history, results and response pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt     <= 1'b1;
         mul_op1      <= '0;
         mul_op2      <= '0;
         mul_op       <= 3'b000;
         mul_start    <= 1'b0;
         busy         <= 1'b0;
         r0_rsp_valid <= 1'b0;
         r1_rsp_valid <= 1'b0;
         r0_result    <= '0;
         r1_result    <= '0;
      end else begin
         mul_start    <= (state_nxt == BUSY);
         busy         <= (state_nxt != IDLE);
         r0_rsp_valid <= rsp & ~last_gnt;
         r1_rsp_valid <= rsp & last_gnt;
         if (accept) begin
            last_gnt <= sel;
            mul_op1  <= sel ? r1_op1 : r0_op1;
            mul_op2  <= sel ? r1_op2 : r0_op2;
            mul_op   <= sel ? r1_op  : r0_op;
         end
         if (rsp) begin
            if (last_gnt) r1_result <= res_val;
            else          r0_result <= res_val;
         end
      end
   end

`ifdef MUL_ARB_TIMEOUT_EN
   // BUSY watchdog and abort flags
   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt       <= '0;
         r0_rsp_err <= 1'b0;
         r1_rsp_err <= 1'b0;
      end else begin
         tcnt <= (state == BUSY && state_nxt == BUSY) ? tcnt + TW'(1) : '0;
         if (rsp) begin
            if (last_gnt) r1_rsp_err <= tmo;
            else          r0_rsp_err <= tmo;
         end
      end
   end
`else
   assign r0_rsp_err = 1'b0;
   assign r1_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_arb.sv
// Scoreboard bench for mul_arb with a 3-cycle multiplier model attached.
module tb_mul_arb;

   localparam int unsigned SIZE = 32;
   localparam int unsigned TMO  = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            r0_valid, r1_valid;
   logic [SIZE-1:0] r0_op1, r0_op2, r1_op1, r1_op2;
   logic [2:0]      r0_op, r1_op;
   logic            r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid;
   logic [SIZE-1:0] r0_result, r1_result;
   logic            r0_rsp_err, r1_rsp_err;
   logic            mul_start, mul_done, busy;
   logic [SIZE-1:0] mul_op1, mul_op2, mul_result;
   logic [2:0]      mul_op;

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          exp_lat = 4;
   logic [32:0] exp0[$], exp1[$];
   int          acc0[$], acc1[$];
   logic [1:0]  mcnt = 2'd0;
   logic        stub_dead = 1'b0;
   logic        stray = 1'b0;

   mul_arb #(.SIZE(SIZE), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_op1(r0_op1), .r0_op2(r0_op2), .r0_op(r0_op),
      .r0_ready(r0_ready), .r0_rsp_valid(r0_rsp_valid), .r0_result(r0_result),
      .r0_rsp_err(r0_rsp_err),
      .r1_valid(r1_valid), .r1_op1(r1_op1), .r1_op2(r1_op2), .r1_op(r1_op),
      .r1_ready(r1_ready), .r1_rsp_valid(r1_rsp_valid), .r1_result(r1_result),
      .r1_rsp_err(r1_rsp_err),
      .mul_start(mul_start), .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_op(mul_op),
      .mul_result(mul_result), .mul_done(mul_done), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] f_mul(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic signed [32:0] xa, xb;
      logic signed [65:0] p;
      xa = (op == 3'b011) ? $signed({1'b0, a}) : $signed({a[31], a});
      xb = (op == 3'b000 || op == 3'b001) ? $signed({b[31], b}) : $signed({1'b0, b});
      p  = xa * xb;
      return (op == 3'b000) ? p[31:0] : p[63:32];
   endfunction

   // multiplier model: done on the 3rd consecutive start cycle
   always @(posedge clk) begin
      if (rst || !mul_start || mul_done) mcnt <= 2'd0;
      else                               mcnt <= mcnt + 2'd1;
   end
   assign mul_done   = (mul_start && mcnt == 2'd2 && !stub_dead) || stray;
   assign mul_result = f_mul(mul_op, mul_op1, mul_op2);

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // response monitor / scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (r0_ready) acc0.push_back(cyc);
         if (r1_ready) acc1.push_back(cyc);
         if (r0_rsp_valid) begin
            if (exp0.size() == 0) chk("r0_spurious_rsp", 1, 0);
            else begin
               logic [32:0] e;
               int a;
               e = exp0.pop_front();
               a = (acc0.size() != 0) ? acc0.pop_front() : -100;
               chk("r0_result", 64'(r0_result), 64'(e[31:0]));
               chk("r0_err", 64'(r0_rsp_err), 64'(e[32]));
               chk("r0_latency", 64'(cyc - a), 64'(exp_lat));
            end
         end
         if (r1_rsp_valid) begin
            if (exp1.size() == 0) chk("r1_spurious_rsp", 1, 0);
            else begin
               logic [32:0] e;
               int a;
               e = exp1.pop_front();
               a = (acc1.size() != 0) ? acc1.pop_front() : -100;
               chk("r1_result", 64'(r1_result), 64'(e[31:0]));
               chk("r1_err", 64'(r1_rsp_err), 64'(e[32]));
               chk("r1_latency", 64'(cyc - a), 64'(exp_lat));
            end
         end
      end
   end

   task automatic drive(input int r, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [32:0] e);
      if (r == 0) begin
         r0_valid = 1'b1; r0_op = op; r0_op1 = a; r0_op2 = b; exp0.push_back(e);
      end else begin
         r1_valid = 1'b1; r1_op = op; r1_op1 = a; r1_op2 = b; exp1.push_back(e);
      end
   endtask

   task automatic wait_acc(input int r, output int t);
      t = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if ((r == 0) ? r0_ready : r1_ready) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) chk($sformatf("r%0d_accept_timeout", r), 0, 1);
      @(posedge clk); #1;
      if (r == 0) r0_valid = 1'b0;
      else        r1_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && (exp0.size() != 0 || exp1.size() != 0); i++) @(negedge clk);
      chk("drain_empty", 64'(exp0.size() + exp1.size()), 0);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp0.delete(); exp1.delete(); acc0.delete(); acc1.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, td, n;
      int ta0[2], ta1[2];
      logic [2:0]  op;
      logic [31:0] a, b;

      rst = 1'b1;
      r0_valid = 1'b1; r1_valid = 1'b0;
      r0_op1 = '0; r0_op2 = '0; r1_op1 = '0; r1_op2 = '0; r0_op = '0; r1_op = '0;

      // reset values, with a request pending during reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_mul_start", 64'(mul_start), 0);
      chk("rst_r0_ready", 64'(r0_ready), 0);
      chk("rst_rsp_valid", 64'({r0_rsp_valid, r1_rsp_valid}), 0);
      chk("rst_err", 64'({r0_rsp_err, r1_rsp_err}), 0);
      chk("rst_results", 64'({r0_result, r1_result}), 0);
      chk("rst_mul_ops", 64'({mul_op1, mul_op2, mul_op} != '0), 0);
      @(posedge clk); #1;
      r0_valid = 1'b0;
      rst = 1'b0;

      // single r0 MUL 3x5: start cycles and response timing
      drive(0, 3'b000, 32'd3, 32'd5, {1'b0, 32'd15});
      td = cyc;
      wait_acc(0, t0);
      chk("a_accept_cycle", 64'(t0), 64'(td));
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk($sformatf("a_mul_start_c%0d", i), 64'(mul_start), 64'(i < 4));
         if (i == 4) begin
            chk("a_rsp_valid_c4", 64'(r0_rsp_valid), 1);
            chk("a_ops_stable_gap", 64'({mul_op1, mul_op2}), 64'({32'd3, 32'd5}));
         end
      end
      drain();

      // stray done in IDLE must be ignored
      stray = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stray_busy", 64'(busy), 0);
         chk("stray_r0_result", 64'(r0_result), 15);
      end
      @(posedge clk); #1;
      stray = 1'b0;

      // r1 high-half variants
      drive(1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE});
      wait_acc(1, t1);
      drain();
      drive(1, 3'b001, 32'hFFFF_FFFF, 32'h0000_0002, {1'b0, 32'hFFFF_FFFF});
      wait_acc(1, t1);
      drain();
      chk("r0_result_hold", 64'(r0_result), 15);

      // simultaneous requests after reset: r0 first, r1 five cycles later
      do_reset();
      drive(0, 3'b010, 32'h8000_0000, 32'd3, {1'b0, 32'hFFFF_FFFE});
      drive(1, 3'b000, 32'h1234, 32'h10, {1'b0, 32'h12340});
      td = cyc;
      fork
         wait_acc(0, t0);
         wait_acc(1, t1);
      join
      chk("c_r0_first", 64'(t0), 64'(td));
      chk("c_r1_gap", 64'(t1 - t0), 5);
      drain();

      // both held valid: strict alternation every 5 cycles
      fork
         for (int k = 0; k < 2; k++) begin
            op = 3'($urandom_range(3, 0)); a = $urandom; b = $urandom;
            drive(0, op, a, b, {1'b0, f_mul(op, a, b)});
            wait_acc(0, ta0[k]);
         end
         for (int k = 0; k < 2; k++) begin
            logic [2:0] op1;
            logic [31:0] c, d;
            op1 = 3'($urandom_range(3, 0)); c = $urandom; d = $urandom;
            drive(1, op1, c, d, {1'b0, f_mul(op1, c, d)});
            wait_acc(1, ta1[k]);
         end
      join
      chk("d_alt_0", 64'(ta1[0] - ta0[0]), 5);
      chk("d_alt_1", 64'(ta0[1] - ta1[0]), 5);
      chk("d_alt_2", 64'(ta1[1] - ta0[1]), 5);
      drain();

      // reset in the middle of an r0 operation
      drive(0, 3'b000, 32'd11, 32'd13, {1'b0, 32'd143});
      wait_acc(0, t0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp0.delete(); exp1.delete(); acc0.delete(); acc1.delete();
      @(negedge clk);
      chk("e_mul_start_after_rst", 64'(mul_start), 0);
      chk("e_busy_after_rst", 64'(busy), 0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (r0_rsp_valid) n++;
         @(negedge clk);
      end
      chk("e_no_rsp_after_rst", 64'(n), 0);
      @(posedge clk); #1;
      drive(0, 3'b011, 32'h0001_0000, 32'h0003_0000, {1'b0, 32'd3});
      drive(1, 3'b000, 32'd7, 32'd9, {1'b0, 32'd63});
      fork
         wait_acc(0, t0);
         wait_acc(1, t1);
      join
      chk("e_r0_wins_after_rst", 64'(t1 - t0), 5);
      drain();

`ifdef MUL_ARB_TIMEOUT_EN
      // multiplier never finishes: watchdog abort
      stub_dead = 1'b1;
      exp_lat = TMO + 1;
      drive(0, 3'b000, 32'd2, 32'd2, {1'b1, 32'd0});
      wait_acc(0, t0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (r0_rsp_valid) break;
         if (mul_start) n++;
      end
      chk("g_start_cycles", 64'(n), 64'(TMO));
      chk("g_rsp_err", 64'(r0_rsp_err), 1);
      @(negedge clk);
      chk("g_idle_after", 64'(busy), 0);
      @(posedge clk); #1;
      stub_dead = 1'b0;
      exp_lat = 4;
      drain();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
